// File: rtl/kugelblitz_axil_cfg_master.sv
`default_nettype none
// ============================================================================
//  Module   : kugelblitz_axil_cfg_master
//  Purpose  : AXI-lite master issuing single configuration reads/writes to
//             the kugelblitz per-port register file. One command at a time is
//             taken on a valid/ready command channel, run on the bus, and the
//             result returned on a valid/ready response channel. A bounded
//             bus-phase timeout guarantees forward progress.
//  Ports    : clk, rst_n           - clock, asynchronous active-low reset
//             cmd_*                - command channel (addr/data/strb/write)
//             rsp_*                - response channel (data/resp/write/timeout)
//             m_axil_*             - AXI-lite master (AW, W, B, AR, R)
//  Revision : 1.0 - initial release
// ============================================================================
module kugelblitz_axil_cfg_master #(
   parameter int AXIL_DATA_WIDTH = 32,
   parameter int AXIL_ADDR_WIDTH = 32,
   parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
   parameter int TIMEOUT_CYCLES  = 1024,  // 0 disables the timeout
   parameter int TIMEOUT_WIDTH   = 16     // TIMEOUT_CYCLES < 2**TIMEOUT_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   // command channel
   input  logic [AXIL_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [AXIL_DATA_WIDTH-1:0] cmd_data,
   input  logic [AXIL_STRB_WIDTH-1:0] cmd_strb,
   input  logic                       cmd_write,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   // response channel
   output logic [AXIL_DATA_WIDTH-1:0] rsp_data,
   output logic [1:0]                 rsp_resp,
   output logic                       rsp_write,
   output logic                       rsp_timeout,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   // AXI-lite write address
   output logic [AXIL_ADDR_WIDTH-1:0] m_axil_awaddr,
   output logic [2:0]                 m_axil_awprot,
   output logic                       m_axil_awvalid,
   input  logic                       m_axil_awready,
   // AXI-lite write data
   output logic [AXIL_DATA_WIDTH-1:0] m_axil_wdata,
   output logic [AXIL_STRB_WIDTH-1:0] m_axil_wstrb,
   output logic                       m_axil_wvalid,
   input  logic                       m_axil_wready,
   // AXI-lite write response
   input  logic [1:0]                 m_axil_bresp,
   input  logic                       m_axil_bvalid,
   output logic                       m_axil_bready,
   // AXI-lite read address
   output logic [AXIL_ADDR_WIDTH-1:0] m_axil_araddr,
   output logic [2:0]                 m_axil_arprot,
   output logic                       m_axil_arvalid,
   input  logic                       m_axil_arready,
   // AXI-lite read data
   input  logic [AXIL_DATA_WIDTH-1:0] m_axil_rdata,
   input  logic [1:0]                 m_axil_rresp,
   input  logic                       m_axil_rvalid,
   output logic                       m_axil_rready
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WR    = 3'd1,
      ST_WR_B  = 3'd2,
      ST_RD_AR = 3'd3,
      ST_RD_R  = 3'd4,
      ST_RSP   = 3'd5
   } state_t;

   localparam logic [TIMEOUT_WIDTH-1:0] TIMER_MAX   = '1;
   localparam logic [TIMEOUT_WIDTH-1:0] TIMER_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
   localparam logic                     TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
   localparam logic [1:0]               RESP_SLVERR = 2'b10;

   state_t                       state_q, state_d;
   logic                         cmd_ready_q, cmd_ready_d;
   logic [AXIL_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [AXIL_DATA_WIDTH-1:0]   data_q, data_d;
   logic [AXIL_STRB_WIDTH-1:0]   strb_q, strb_d;
   logic                         write_q, write_d;
   logic                         awvalid_q, awvalid_d;
   logic                         wvalid_q, wvalid_d;
   logic                         bready_q, bready_d;
   logic                         arvalid_q, arvalid_d;
   logic                         rready_q, rready_d;
   logic [TIMEOUT_WIDTH-1:0]     timer_q, timer_d;
   logic                         rsp_valid_q, rsp_valid_d;
   logic [AXIL_DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic [1:0]                   rsp_resp_q, rsp_resp_d;
   logic                         rsp_timeout_q, rsp_timeout_d;

   logic [TIMEOUT_WIDTH-1:0]     timer_inc;
   logic                         expired;
   logic                         abort;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cmd_ready_q   <= 1'b0;
         addr_q        <= '0;
         data_q        <= '0;
         strb_q        <= '0;
         write_q       <= 1'b0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         timer_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_resp_q    <= 2'b00;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         strb_q        <= strb_d;
         write_q       <= write_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         bready_q      <= bready_d;
         arvalid_q     <= arvalid_d;
         rready_q      <= rready_d;
         timer_q       <= timer_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state / output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      cmd_ready_d   = cmd_ready_q;
      addr_d        = addr_q;
      data_d        = data_q;
      strb_d        = strb_q;
      write_d       = write_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      bready_d      = bready_q;
      arvalid_d     = arvalid_q;
      rready_d      = rready_q;
      timer_d       = timer_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_data_d    = rsp_data_q;
      rsp_resp_d    = rsp_resp_q;
      rsp_timeout_d = rsp_timeout_q;
      abort         = 1'b0;

      // timer_inc counts bus-phase cycles including the current one, so the
      // limit is reached in the TIMEOUT_CYCLES-th cycle spent on the bus.
      timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
      expired   = TIMEOUT_EN && (timer_inc == TIMER_LIMIT);

      case (state_q)
         ST_IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               addr_d      = cmd_addr;
               data_d      = cmd_data;
               strb_d      = cmd_strb;
               write_d     = cmd_write;
               timer_d     = '0;
               if (cmd_write) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = ST_WR;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = ST_RD_AR;
               end
            end
         end

         ST_WR: begin
            timer_d = timer_inc;
            if (expired) begin
               abort = 1'b1;
            end else begin
               // AW and W retire independently; either order or together.
               if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
               if (wvalid_q && m_axil_wready)   wvalid_d  = 1'b0;
               if (!awvalid_d && !wvalid_d) begin
                  bready_d = 1'b1;
                  state_d  = ST_WR_B;
               end
            end
         end

         ST_WR_B: begin
            timer_d = timer_inc;
            // a B beat in the expiry cycle still completes normally
            if (m_axil_bvalid) begin
               bready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_data_d    = '0;
               rsp_resp_d    = m_axil_bresp;
               rsp_timeout_d = 1'b0;
               state_d       = ST_RSP;
            end else if (expired) begin
               abort = 1'b1;
            end
         end

         ST_RD_AR: begin
            timer_d = timer_inc;
            if (expired) begin
               abort = 1'b1;
            end else if (m_axil_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_RD_R;
            end
         end

         ST_RD_R: begin
            timer_d = timer_inc;
            if (m_axil_rvalid) begin
               rready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_data_d    = m_axil_rdata;
               rsp_resp_d    = m_axil_rresp;
               rsp_timeout_d = 1'b0;
               state_d       = ST_RSP;
            end else if (expired) begin
               abort = 1'b1;
            end
         end

         ST_RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Timeout: withdraw every bus request and report a slave error.
      if (abort) begin
         awvalid_d     = 1'b0;
         wvalid_d      = 1'b0;
         bready_d      = 1'b0;
         arvalid_d     = 1'b0;
         rready_d      = 1'b0;
         rsp_valid_d   = 1'b1;
         rsp_data_d    = '0;
         rsp_resp_d    = RESP_SLVERR;
         rsp_timeout_d = 1'b1;
         state_d       = ST_RSP;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs (all registered)
   // ------------------------------------------------------------------------
   assign cmd_ready      = cmd_ready_q;
   assign rsp_data       = rsp_data_q;
   assign rsp_resp       = rsp_resp_q;
   assign rsp_write      = write_q;
   assign rsp_timeout    = rsp_timeout_q;
   assign rsp_valid      = rsp_valid_q;
   assign m_axil_awaddr  = addr_q;
   assign m_axil_awprot  = 3'b000;
   assign m_axil_awvalid = awvalid_q;
   assign m_axil_wdata   = data_q;
   assign m_axil_wstrb   = strb_q;
   assign m_axil_wvalid  = wvalid_q;
   assign m_axil_bready  = bready_q;
   assign m_axil_araddr  = addr_q;
   assign m_axil_arprot  = 3'b000;
   assign m_axil_arvalid = arvalid_q;
   assign m_axil_rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_kugelblitz_axil_cfg_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kugelblitz_axil_cfg_master
//  Purpose  : Self-checking bench for kugelblitz_axil_cfg_master. A delay-
//             configurable AXI-lite slave answers the master; expected
//             responses, latencies and beat counts come from a table of
//             constants or from an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_kugelblitz_axil_cfg_master;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int SW = 4;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_data = '0;
   logic [SW-1:0] cmd_strb = '0;
   logic          cmd_write = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [DW-1:0] rsp_data;
   logic [1:0]    rsp_resp;
   logic          rsp_write, rsp_timeout, rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
   logic [2:0]    m_axil_awprot, m_axil_arprot;
   logic          m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready;
   logic [DW-1:0] m_axil_wdata;
   logic [SW-1:0] m_axil_wstrb;
   logic          m_axil_awready = 1'b0, m_axil_wready = 1'b0, m_axil_arready = 1'b0;
   logic          m_axil_bvalid = 1'b0, m_axil_rvalid = 1'b0;
   logic [1:0]    m_axil_bresp = 2'b00, m_axil_rresp = 2'b00;
   logic [DW-1:0] m_axil_rdata = '0;

   kugelblitz_axil_cfg_master #(
      .AXIL_DATA_WIDTH(DW), .AXIL_ADDR_WIDTH(AW), .AXIL_STRB_WIDTH(SW),
      .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(16)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
      .cmd_write(cmd_write), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_write(rsp_write),
      .rsp_timeout(rsp_timeout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
      .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
      .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
      .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
      .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
      .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
      .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
      .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
      .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
   );

   always #5 clk = ~clk;

   // every DUT output, for the "all outputs zero" reset checks
   wire [148:0] all_out = {cmd_ready, rsp_valid, rsp_data, rsp_resp, rsp_write, rsp_timeout,
                           m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid,
                           m_axil_rready, m_axil_awaddr, m_axil_wdata, m_axil_wstrb,
                           m_axil_araddr, m_axil_awprot, m_axil_arprot};

   int n_tests = 0;
   int n_fail  = 0;

   // slave configuration and observation counters
   int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
   logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
   logic [31:0] cfg_rdata = '0;
   logic [31:0] exp_addr = '0, exp_data = '0;
   logic [3:0]  exp_strb = '0;
   int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
   int aw_hi = 0, w_hi = 0, b_hi = 0, ar_hi = 0, r_hi = 0;
   int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
   int stab_err = 0, overlap_err = 0;

   typedef struct {
      logic        w;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          d_a;     // AW (write) or AR (read) ready delay
      int          d_w;     // W ready delay
      int          d_b;     // B (write) or R (read) valid delay
      logic [1:0]  sresp;
      logic [31:0] srdata;
      logic [31:0] e_data;
      logic [1:0]  e_resp;
      int          e_lat;   // cycles from accept to first rsp_valid cycle
   } vec_t;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: response contents follow the slave's answer; latency is
   // the bus-phase length implied by the slave's delays.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      int   m = (v.d_a > v.d_w) ? v.d_a : v.d_w;
      r.e_data = v.w ? 32'h0 : v.srdata;
      r.e_resp = v.sresp;
      r.e_lat  = v.w ? (m + 1) + (v.d_b + 1) : (v.d_a + 1) + (v.d_b + 1);
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // AXI-lite slave: decides ready/valid at each falling edge
   // ------------------------------------------------------------------------
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
            m_axil_bvalid = 0; m_axil_rvalid = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
         end else begin
            if ((m_axil_awvalid || m_axil_wvalid) && m_axil_arvalid) overlap_err++;
            if (m_axil_awvalid) begin
               aw_hi++;
               if (m_axil_awaddr !== exp_addr) stab_err++;
               if (aw_wait >= aw_delay) begin m_axil_awready = 1; aw_hs++; end
               else begin m_axil_awready = 0; aw_wait++; end
            end else begin m_axil_awready = 0; aw_wait = 0; end
            if (m_axil_wvalid) begin
               w_hi++;
               if (m_axil_wdata !== exp_data || m_axil_wstrb !== exp_strb) stab_err++;
               if (w_wait >= w_delay) begin m_axil_wready = 1; w_hs++; end
               else begin m_axil_wready = 0; w_wait++; end
            end else begin m_axil_wready = 0; w_wait = 0; end
            if (m_axil_bready) begin
               b_hi++;
               if (b_wait >= b_delay) begin m_axil_bvalid = 1; m_axil_bresp = cfg_bresp; b_hs++; end
               else begin m_axil_bvalid = 0; b_wait++; end
            end else begin m_axil_bvalid = 0; b_wait = 0; end
            if (m_axil_arvalid) begin
               ar_hi++;
               if (m_axil_araddr !== exp_addr) stab_err++;
               if (ar_wait >= ar_delay) begin m_axil_arready = 1; ar_hs++; end
               else begin m_axil_arready = 0; ar_wait++; end
            end else begin m_axil_arready = 0; ar_wait = 0; end
            if (m_axil_rready) begin
               r_hi++;
               if (r_wait >= r_delay) begin
                  m_axil_rvalid = 1; m_axil_rresp = cfg_rresp; m_axil_rdata = cfg_rdata; r_hs++;
               end else begin m_axil_rvalid = 0; r_wait++; end
            end else begin m_axil_rvalid = 0; r_wait = 0; end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Command / response helpers
   // ------------------------------------------------------------------------
   task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      @(posedge clk); #1;
      aw_hi = 0; w_hi = 0; b_hi = 0; ar_hi = 0; r_hi = 0;
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      exp_addr = a; exp_data = d; exp_strb = s;
      cmd_write = w; cmd_addr = a; cmd_data = d; cmd_strb = s; cmd_valid = 1'b1;
      @(negedge clk);
      while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
      chk("cmd_accept", cmd_ready, 1'b1);
      @(posedge clk); #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output logic [31:0] d, output logic [1:0] r, output logic wr,
                           output logic to, output int lat);
      lat = 0;
      @(negedge clk);
      while (!rsp_valid && lat < 300) begin lat++; @(negedge clk); end
      chk("rsp_arrive", rsp_valid, 1'b1);
      d = rsp_data; r = rsp_resp; wr = rsp_write; to = rsp_timeout;
   endtask

   task automatic pop_rsp();
      rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
   endtask

   task automatic apply(input vec_t v, input string nm);
      logic [31:0] d; logic [1:0] r; logic wr, to; int lat;
      aw_delay = v.d_a; ar_delay = v.d_a; w_delay = v.d_w; b_delay = v.d_b; r_delay = v.d_b;
      cfg_bresp = v.sresp; cfg_rresp = v.sresp; cfg_rdata = v.srdata;
      send_cmd(v.w, v.addr, v.data, v.strb);
      wait_rsp(d, r, wr, to, lat);
      pop_rsp();
      chk({nm, "_rsp"}, {d, r, wr, to}, {v.e_data, v.e_resp, v.w, 1'b0});
      chk({nm, "_latency"}, lat, v.e_lat);
      if (v.w) begin
         chk({nm, "_beats"}, {aw_hs, w_hs, b_hs, ar_hs, r_hs}, {32'd1, 32'd1, 32'd1, 32'd0, 32'd0});
         chk({nm, "_vcycles"}, {aw_hi, w_hi, b_hi}, {v.d_a + 1, v.d_w + 1, v.d_b + 1});
      end else begin
         chk({nm, "_beats"}, {aw_hs, w_hs, b_hs, ar_hs, r_hs}, {32'd0, 32'd0, 32'd0, 32'd1, 32'd1});
         chk({nm, "_vcycles"}, {ar_hi, r_hi}, {v.d_a + 1, v.d_b + 1});
      end
   endtask

   // ------------------------------------------------------------------------
   // Watchdog
   // ------------------------------------------------------------------------
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   // ------------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------------
   initial begin
      vec_t        tbl[6];
      vec_t        v;
      logic [31:0] d; logic [1:0] r; logic wr, to; int lat;
      logic [35:0] snap;
      int          bad;

      //          w     addr          data          strb  dA dW dB resp   rdata          e_data         e_resp e_lat
      tbl[0] = '{1'b1, 32'h0000_0008, 32'hA5A5_0001, 4'hF, 0, 3, 0, 2'b00, 32'h0,         32'h0,         2'b00, 5};
      tbl[1] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 2, 0, 0, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 4};
      tbl[2] = '{1'b1, 32'h0000_0018, 32'h1234_5678, 4'h3, 0, 0, 0, 2'b10, 32'h0,         32'h0,         2'b10, 2};
      tbl[3] = '{1'b1, 32'h0000_001C, 32'hCAFE_F00D, 4'hC, 2, 0, 1, 2'b00, 32'h0,         32'h0,         2'b00, 5};
      tbl[4] = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 0, 0, 2, 2'b01, 32'h0BAD_F00D, 32'h0BAD_F00D, 2'b01, 4};
      // R beat lands in the very cycle the timeout limit is reached: normal response
      tbl[5] = '{1'b0, 32'h0000_0028, 32'h0,         4'h0, 0, 0, 14, 2'b00, 32'h1357_9BDF, 32'h1357_9BDF, 2'b00, 16};

      // reset state
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs_zero", all_out, '0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("cmd_ready_after_reset", cmd_ready, 1'b1);

      // table vectors
      for (int i = 0; i < 6; i++) apply(tbl[i], $sformatf("vec%0d", i));

      // randomized transactions against the reference model
      for (int i = 0; i < 24; i++) begin
         v.w      = 1'($urandom_range(0, 1));
         v.addr   = $urandom & 32'h0000_0FFC;
         v.data   = $urandom;
         v.strb   = 4'($urandom_range(0, 15));
         v.d_a    = int'($urandom_range(0, 3));
         v.d_w    = int'($urandom_range(0, 3));
         v.d_b    = int'($urandom_range(0, 3));
         v.sresp  = 2'($urandom_range(0, 3));
         v.srdata = $urandom;
         v = model(v);
         apply(v, $sformatf("rnd%0d", i));
      end

      // read timeout: AR never accepted
      v = '{1'b0, 32'h30, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h7777_8888, 32'h0, 2'b00, 0};
      apply(model(v), "pre_to");
      ar_delay = 1000;
      send_cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0);
      wait_rsp(d, r, wr, to, lat);
      pop_rsp();
      chk("to_rsp", {d, r, wr, to}, {32'h0, 2'b10, 1'b0, 1'b1});
      chk("to_latency", lat, TO);
      chk("to_ar_cycles", {ar_hi, ar_hs, r_hi}, {TO, 32'd0, 32'd0});
      v = '{1'b0, 32'h34, 32'h0, 4'h0, 1, 0, 0, 2'b00, 32'h600D_CAFE, 32'h0, 2'b00, 0};
      apply(model(v), "after_to");

      // response back-pressure with the next command already pending
      aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
      cfg_bresp = 2'b01; cfg_rresp = 2'b00; cfg_rdata = 32'h5A5A_A5A5;
      send_cmd(1'b1, 32'h0000_0050, 32'hFEED_FACE, 4'h5);
      wait_rsp(d, r, wr, to, lat);
      snap = {rsp_data, rsp_resp, rsp_write, rsp_timeout};
      chk("bp_first_rsp", snap, {32'h0, 2'b01, 1'b1, 1'b0});
      cmd_write = 1'b0; cmd_addr = 32'h0000_0054; cmd_valid = 1'b1; exp_addr = 32'h0000_0054;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if ({rsp_data, rsp_resp, rsp_write, rsp_timeout} !== snap || !rsp_valid || cmd_ready) bad++;
      end
      chk("bp_hold_stable", bad, 0);
      rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk("bp_next_ready", {cmd_ready, rsp_valid}, 2'b10);
      @(posedge clk); #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk("bp_next_issued", {m_axil_arvalid, cmd_ready}, 2'b10);
      wait_rsp(d, r, wr, to, lat);
      pop_rsp();
      chk("bp_next_rsp", {d, r, wr, to}, {32'h5A5A_A5A5, 2'b00, 1'b0, 1'b0});

      // reset asserted mid-write
      aw_delay = 50; w_delay = 50;
      send_cmd(1'b1, 32'h0000_0040, 32'h1111_2222, 4'hF);
      repeat (3) @(negedge clk);
      chk("rst_valids_up", {m_axil_awvalid, m_axil_wvalid}, 2'b11);
      #2 rst_n = 1'b0;
      #1 chk("rst_async_zero", all_out, '0);
      aw_delay = 0; w_delay = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      bad = 0;
      repeat (6) begin
         if (rsp_valid || m_axil_awvalid || m_axil_wvalid) bad++;
         @(negedge clk);
      end
      chk("rst_no_rsp", bad, 0);

      chk("addr_data_stable", stab_err, 0);
      chk("no_aw_ar_overlap", overlap_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
